// File: rtl/xpmwrap_tdpram_arbiter.sv
// Two-requester round-robin front end for one port of a true-dual-port RAM.
// It zero-fills the RAM after reset, then issues one access per cycle and returns read data in order.
module xpmwrap_tdpram_arbiter #(
    parameter int ADDR_WIDTH     = 6,
    parameter int DATA_WIDTH     = 32,
    parameter int READ_LATENCY   = 2,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic                  req0_we,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic                  req1_we,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  rsp0_valid,
    output logic [DATA_WIDTH-1:0] rsp0_rdata,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp1_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    output logic                  mem_regce,
    output logic                  mem_rst,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    output logic                  init_done
);

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t                  state_reg, state_next;
    logic [ADDR_WIDTH:0]     clr_cnt_reg, clr_cnt_next;
    logic                    last_reg;
    logic                    init_done_reg;
    logic                    grant0, grant1, rd_accept;
    logic                    mem_en_reg, mem_en_next;
    logic                    mem_we_reg, mem_we_next;
    logic [ADDR_WIDTH-1:0]   mem_addr_reg, mem_addr_next;
    logic [DATA_WIDTH-1:0]   mem_din_reg, mem_din_next;
    logic                    mem_regce_reg;
    logic [READ_LATENCY:0]   rv_reg, rid_reg;

    always_comb begin
        state_next    = state_reg;
        clr_cnt_next  = clr_cnt_reg;
        grant0        = 1'b0;
        grant1        = 1'b0;
        mem_en_next   = 1'b0;
        mem_we_next   = 1'b0;
        mem_addr_next = req0_addr;
        mem_din_next  = req0_wdata;
        case (state_reg)
            ST_CLEAR: begin
                // Counter MSB marks that the last address has already been written.
                if (clr_cnt_reg[ADDR_WIDTH]) begin
                    state_next = ST_RUN;
                end else begin
                    mem_en_next   = 1'b1;
                    mem_we_next   = 1'b1;
                    mem_addr_next = clr_cnt_reg[ADDR_WIDTH-1:0];
                    mem_din_next  = '0;
                    clr_cnt_next  = clr_cnt_reg + 1'b1;
                end
            end
            default: begin
                if (init_done_reg) begin
                    // last_reg=1 means req1 won last, so req0 has priority on contention.
                    grant0 = req0_valid & (~req1_valid | last_reg);
                    grant1 = req1_valid & (~req0_valid | ~last_reg);
                    if (grant1) begin
                        mem_addr_next = req1_addr;
                        mem_din_next  = req1_wdata;
                    end
                    mem_en_next = grant0 | grant1;
                    mem_we_next = (grant0 & req0_we) | (grant1 & req1_we);
                end
            end
        endcase
    end

    assign rd_accept = (grant0 & ~req0_we) | (grant1 & ~req1_we);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            clr_cnt_reg   <= '0;
            last_reg      <= 1'b1;
            init_done_reg <= 1'b0;
            mem_en_reg    <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_din_reg   <= '0;
            mem_regce_reg <= 1'b0;
            rv_reg        <= '0;
            rid_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            clr_cnt_reg   <= clr_cnt_next;
            if (grant0 | grant1) begin
                last_reg <= grant1;
            end
            init_done_reg <= init_done_reg | (state_next == ST_RUN);
            mem_en_reg    <= mem_en_next;
            mem_we_reg    <= mem_we_next;
            mem_addr_reg  <= mem_addr_next;
            mem_din_reg   <= mem_din_next;
            mem_regce_reg <= 1'b1;
            // Stage k holds reads issued k+1 cycles ago; the last stage lines up with mem_dout.
            rv_reg        <= {rv_reg[READ_LATENCY-1:0], rd_accept};
            rid_reg       <= {rid_reg[READ_LATENCY-1:0], grant1};
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign rsp0_valid = rv_reg[READ_LATENCY] & ~rid_reg[READ_LATENCY];
    assign rsp1_valid = rv_reg[READ_LATENCY] & rid_reg[READ_LATENCY];
    assign rsp0_rdata = mem_dout;
    assign rsp1_rdata = mem_dout;
    assign mem_en     = mem_en_reg;
    assign mem_we     = mem_we_reg;
    assign mem_addr   = mem_addr_reg;
    assign mem_din    = mem_din_reg;
    assign mem_regce  = mem_regce_reg;
    assign mem_rst    = 1'b0;
    assign init_done  = init_done_reg;

endmodule

// File: tb/tb_xpmwrap_tdpram_arbiter.sv
// Bench for xpmwrap_tdpram_arbiter: behavioral RAM port, reference memory and an in-order response scoreboard.
module tb_xpmwrap_tdpram_arbiter;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req0_we = 1'b0, req1_valid = 1'b0, req1_we = 1'b0;
    logic [5:0]  req0_addr = '0, req1_addr = '0;
    logic [31:0] req0_wdata = '0, req1_wdata = '0;
    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [31:0] rsp0_rdata, rsp1_rdata;
    logic        mem_en, mem_we, mem_regce, mem_rst, init_done;
    logic [5:0]  mem_addr;
    logic [31:0] mem_din, mem_dout;

    // second instance without the zero-fill phase
    logic        n_rst_n = 1'b0;
    logic        n_req0_valid = 1'b0, n_req1_valid = 1'b0;
    logic        n_req0_ready, n_req1_ready, n_rsp0_valid, n_rsp1_valid;
    logic [31:0] n_rsp0_rdata, n_rsp1_rdata, n_mem_din;
    logic        n_mem_en, n_mem_we, n_mem_regce, n_mem_rst, n_init_done;
    logic [5:0]  n_mem_addr;
    logic [31:0] n_mem_dout = '0;

    int checks = 0;
    int errors = 0;
    int rsp1_seen = 0;

    typedef struct {
        bit          id;
        logic [31:0] data;
    } exp_t;
    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [31:0] ref_mem [64];

    always #5 clk = ~clk;

    xpmwrap_tdpram_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_regce(mem_regce), .mem_rst(mem_rst), .mem_dout(mem_dout),
        .init_done(init_done)
    );

    xpmwrap_tdpram_arbiter #(.CLEAR_ON_RESET(0)) dut_nc (
        .clk(clk), .rst_n(n_rst_n),
        .req0_valid(n_req0_valid), .req0_ready(n_req0_ready), .req0_we(1'b0),
        .req0_addr(6'd0), .req0_wdata(32'd0),
        .req1_valid(n_req1_valid), .req1_ready(n_req1_ready), .req1_we(1'b0),
        .req1_addr(6'd1), .req1_wdata(32'd0),
        .rsp0_valid(n_rsp0_valid), .rsp0_rdata(n_rsp0_rdata),
        .rsp1_valid(n_rsp1_valid), .rsp1_rdata(n_rsp1_rdata),
        .mem_en(n_mem_en), .mem_we(n_mem_we), .mem_addr(n_mem_addr), .mem_din(n_mem_din),
        .mem_regce(n_mem_regce), .mem_rst(n_mem_rst), .mem_dout(n_mem_dout),
        .init_done(n_init_done)
    );

    // behavioral RAM port: registered read followed by output register stages
    logic [31:0] ram [64];
    logic [31:0] pipe [LAT];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_din;
            pipe[0] <= ram[mem_addr];
        end
        for (int i = 1; i < LAT; i++) if (mem_regce) pipe[i] <= pipe[i-1];
    end
    assign mem_dout = pipe[LAT-1];

    // accepts feed the reference memory and scoreboard; responses are popped in order
    always @(negedge clk) begin
        if (rst_n) begin
            if (req0_valid && req0_ready) begin
                if (req0_we) ref_mem[req0_addr] = req0_wdata;
                else sb_q.push_back('{1'b0, ref_mem[req0_addr]});
            end
            if (req1_valid && req1_ready) begin
                if (req1_we) ref_mem[req1_addr] = req1_wdata;
                else sb_q.push_back('{1'b1, ref_mem[req1_addr]});
            end
            if (rsp1_valid) rsp1_seen++;
            if (rsp0_valid || rsp1_valid) begin
                checks++;
                if (rsp0_valid && rsp1_valid) begin
                    errors++;
                    $display("FAIL rsp_both: rsp0_valid=1 rsp1_valid=1 required one-hot");
                end else if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_unexpected: rsp0_valid=%0b rsp1_valid=%0b required none", rsp0_valid, rsp1_valid);
                end else begin
                    mon_e = sb_q.pop_front();
                    if (rsp1_valid !== mon_e.id || (rsp1_valid ? rsp1_rdata : rsp0_rdata) !== mon_e.data) begin
                        errors++;
                        $display("FAIL rsp_data: id=%0b data=%h required id=%0b data=%h", rsp1_valid,
                                 rsp1_valid ? rsp1_rdata : rsp0_rdata, mon_e.id, mon_e.data);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        logic [40:0] got, exp;
        req0_valid = 1'b1;
        req0_we    = 1'b0;
        #23;
        checks++;
        got = {mem_en, mem_we, mem_addr, mem_din, req0_ready, init_done};
        if (got !== 41'd0 || mem_regce !== 1'b0 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: en/we/addr/din/rdy/done=%h regce=%0b required all 0", got, mem_regce);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(posedge clk); @(negedge clk);
            got = {mem_en, mem_we, mem_addr, mem_din, req0_ready, init_done};
            exp = {1'b1, 1'b1, 6'(i), 32'd0, 1'b0, 1'b0};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL clear_cycle%0d: en/we/addr/din/rdy/done=%h required %h", i + 1, got, exp);
            end
        end
        checks++;
        if (mem_regce !== 1'b1 || mem_rst !== 1'b0) begin
            errors++;
            $display("FAIL regce_rst: regce=%0b rst=%0b required 1/0", mem_regce, mem_rst);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (init_done !== 1'b1 || mem_we !== 1'b0 || mem_en !== 1'b0) begin
            errors++;
            $display("FAIL clear_done: init_done=%0b we=%0b en=%0b required 1/0/0", init_done, mem_we, mem_en);
        end
    endtask

    task automatic test_round_robin();
        int j;
        logic exp0, exp1;
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 6'd1;
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 6'd2;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k < 4) begin
                checks++;
                if (req0_ready !== (k % 2 == 0) || req1_ready !== (k % 2 == 1)) begin
                    errors++;
                    $display("FAIL rr_grant%0d: ready0=%0b ready1=%0b required %0b/%0b", k, req0_ready,
                             req1_ready, k % 2 == 0, k % 2 == 1);
                end
            end
            j = k - 3;
            exp0 = (j >= 0) && (j < 4) && (j % 2 == 0);
            exp1 = (j >= 0) && (j < 4) && (j % 2 == 1);
            checks++;
            if (rsp0_valid !== exp0 || rsp1_valid !== exp1) begin
                errors++;
                $display("FAIL rr_rsp%0d: rsp0=%0b rsp1=%0b required %0b/%0b", k, rsp0_valid, rsp1_valid, exp0, exp1);
            end
            @(posedge clk); #1;
            if (k == 3) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
        end
    endtask

    task automatic test_clear_readback();
        int seen0;
        seen0 = rsp1_seen;
        req1_valid = 1'b1;
        req1_we    = 1'b0;
        for (int i = 0; i < 64; i++) begin
            req1_addr = 6'(i);
            @(negedge clk);
            checks++;
            if (req1_ready !== 1'b1) begin
                errors++;
                $display("FAIL readback_ready%0d: ready1=%0b required 1", i, req1_ready);
            end
            @(posedge clk); #1;
        end
        req1_valid = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (rsp1_seen - seen0 != 64 || sb_q.size() != 0) begin
            errors++;
            $display("FAIL readback_count: responses=%0d pending=%0d required 64/0", rsp1_seen - seen0, sb_q.size());
        end
    endtask

    task automatic test_write_read();
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 6'd5; req0_wdata = 32'hDEADBEEF;
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++;
            $display("FAIL wr_ready: ready0=%0b required 1", req0_ready);
        end
        @(posedge clk); #1;
        req0_we = 1'b0;
        @(negedge clk);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            if (k == 1) req0_valid = 1'b0;
            @(negedge clk);
            checks++;
            if (rsp0_valid !== (k == 3) || rsp1_valid !== 1'b0 || (k == 3 && rsp0_rdata !== 32'hDEADBEEF)) begin
                errors++;
                $display("FAIL wr_rd_rsp%0d: rsp0=%0b rsp1=%0b rdata=%h required %0b/0/DEADBEEF", k,
                         rsp0_valid, rsp1_valid, rsp0_rdata, k == 3);
            end
        end
    endtask

    task automatic test_reset_midop();
        logic [40:0] got;
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 6'd5;
        @(posedge clk); #1;
        req0_addr = 6'd1;
        @(posedge clk); #1;
        #3;
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        got = {mem_en, mem_we, mem_addr, mem_din, req0_ready, init_done};
        checks++;
        if (got !== 41'd0 || mem_regce !== 1'b0 || mem_rst !== 1'b0 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: en/we/addr/din/rdy/done=%h regce=%0b required all 0", got, mem_regce);
        end
        req0_valid = 1'b0;
        for (int i = 0; i < 64; i++) ref_mem[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); @(negedge clk);
            checks++;
            if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 6'(c - 1)) begin
                errors++;
                $display("FAIL restart_cycle%0d: rsp0=%0b rsp1=%0b we=%0b addr=%0d required 0/0/1/%0d", c,
                         rsp0_valid, rsp1_valid, mem_we, mem_addr, c - 1);
            end
        end
    endtask

    task automatic test_no_clear();
        n_req0_valid = 1'b1;
        n_req1_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (n_init_done !== 1'b0 || n_req0_ready !== 1'b0 || n_req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL nc_reset: init_done=%0b ready0=%0b ready1=%0b required 0/0/0", n_init_done,
                     n_req0_ready, n_req1_ready);
        end
        @(posedge clk); #1;
        n_rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        checks++;
        if (n_init_done !== 1'b1 || n_req0_ready !== 1'b1 || n_req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL nc_first: init_done=%0b ready0=%0b ready1=%0b required 1/1/0", n_init_done,
                     n_req0_ready, n_req1_ready);
        end
        @(posedge clk); @(negedge clk);
        checks++;
        if (n_req0_ready !== 1'b0 || n_req1_ready !== 1'b1) begin
            errors++;
            $display("FAIL nc_second: ready0=%0b ready1=%0b required 0/1", n_req0_ready, n_req1_ready);
        end
        n_req0_valid = 1'b0;
        n_req1_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ref_mem[i] = '0;
        test_reset();
        test_round_robin();
        test_clear_readback();
        test_write_read();
        test_reset_midop();
        test_no_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/xpmwrap_tdpram_arbiter.md
XPMWRAP_TDPRAM_ARBITER -- requirements
Module: xpmwrap_tdpram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 6, RAM word address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, RAM word width.
REQ-003 SHALL have parameter READ_LATENCY, default 2, RAM port read latency in cycles (1..4).
REQ-004 SHALL have parameter CLEAR_ON_RESET, default 1, 1 = zero-fill the RAM after reset.
REQ-005 SHALL have one clock: clk  in  1  all logic on rising edge.
REQ-006 SHALL have reset rst_n  in  1  asynchronous, active-low.
REQ-007 SHALL have, for n in {0,1}: reqn_valid in 1 request; reqn_ready out 1 grant; reqn_we in 1 1=write 0=read; reqn_addr in ADDR_WIDTH; reqn_wdata in DATA_WIDTH.
REQ-008 SHALL have, for n in {0,1}: rspn_valid out 1 read data valid; rspn_rdata out DATA_WIDTH read data.
REQ-009 SHALL have RAM-port outputs mem_en 1, mem_we 1, mem_addr ADDR_WIDTH, mem_din DATA_WIDTH, mem_regce 1, mem_rst 1; input mem_dout DATA_WIDTH.
REQ-010 SHALL have init_done  out  1  high once the RAM is usable.

Function
REQ-011 SHALL implement states CLEAR and RUN; after reset: CLEAR if CLEAR_ON_RESET=1, else RUN.
REQ-012 In CLEAR SHALL drive registered mem_en=1, mem_we=1, mem_din=0, mem_addr = clear counter from 0 incrementing by 1 per cycle; reqn_ready=0.
REQ-013 SHALL leave CLEAR after the write to address 2^ADDR_WIDTH-1 (2^ADDR_WIDTH write cycles, no wrap) and set init_done=1 in the first RUN cycle; init_done stays 1 until reset.
REQ-014 In RUN, reqn_ready SHALL be combinational: single valid requester is granted; with both valid, grant the requester not granted last (round-robin).
REQ-015 Last-granted pointer SHALL update on every accept (valid & ready); after reset it indicates req1, so req0 wins first contention.
REQ-016 SHALL accept at most one request per cycle, sustaining one per cycle back-to-back.
REQ-017 An accept in cycle T SHALL drive registered mem_en=1, mem_we=reqn_we, mem_addr, mem_din in cycle T+1; with no accept, mem_en=0, mem_we=0.
REQ-018 A read accepted in cycle T SHALL assert rspn_valid for exactly one cycle at T+1+READ_LATENCY, routed to the originating requester only, via a READ_LATENCY+1 deep valid/id shift register.
REQ-019 rspn_rdata SHALL equal mem_dout (unregistered); content is meaningful only when rspn_valid=1.
REQ-020 Writes SHALL produce no response; responses have no backpressure.
REQ-021 Responses SHALL return in acceptance order; rsp0_valid and rsp1_valid never both 1.
REQ-022 mem_regce SHALL be 1 and mem_rst SHALL be 0 at all times after reset.
REQ-023 Read of an address written in an earlier accept SHALL return the written data (ordering by RAM port only, no bypass needed).

Reset
REQ-024 Reset assertion SHALL immediately force mem_en, mem_we, mem_addr, mem_din, reqn_ready, rspn_valid, init_done, mem_rst to 0 and mem_regce to 0.
REQ-025 Reset mid-operation SHALL discard all in-flight reads (no rspn_valid after release for pre-reset requests) and restart CLEAR from address 0.
REQ-026 On release, state and pointer SHALL take the values of REQ-011/REQ-015 on the first clock edge.

Verification
REQ-027 Reset release, defaults -> mem_we=1 for exactly 64 cycles, addresses 0..63, din 0; init_done=1 in cycle 65; no ready during clear.
REQ-028 req0 write addr 5 data 0xDEADBEEF, next cycle req0 read addr 5 -> rsp0_valid exactly 3 cycles after read accept, rsp0_rdata=0xDEADBEEF, rsp1_valid stays 0.
REQ-029 Both requesters hold valid reads (addr 1, addr 2) for 4 cycles -> grants alternate 0,1,0,1; responses alternate rsp0, rsp1 in same order, one per cycle.
REQ-030 After clear, read all 64 addresses from req1 -> every rdata 0.
REQ-031 Assert rst_n low 1 cycle after two reads accepted -> outputs 0 asynchronously; no rspn_valid after release; clear restarts at 0.
REQ-032 CLEAR_ON_RESET=0 -> init_done=1 and req0 granted in first cycle after release.
